msg_fifo_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the image-processor message FIFO between up to N_REQ independent message producers. Examples are per-colour bounding-box reporters, a frame-statistics reporter and a debug reporter. Each granted producer writes its whole multi-word message contiguously. A message is admitted only when the FIFO has room for all of its words, so a CPU reader never sees a partial message. The block sits between the producers and the message FIFO, which is drained by the Avalon-MM slave.

---
 rtl/msg_fifo_arbiter.sv | 160 ++++++++++++++++
 tb/tb_msg_fifo_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_fifo_arbiter.sv
// Round-robin arbiter sharing one message-FIFO write port between N_REQ producers.
// A message is granted only when the FIFO has room for all of its words.
module msg_fifo_arbiter #(
  parameter int unsigned N_REQ      = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned USEDW_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [LEN_W-1:0]          word_idx,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      fifo_wr,
  input  logic [USEDW_W-1:0]        fifo_usedw,
  input  logic                      flush,
  output logic                      busy,
  output logic [15:0]               stall_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [USEDW_W:0] ROOM_MAX = (USEDW_W+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   zdone_q, zdone_d;
  logic [LEN_W-1:0]   word_idx_q, word_idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        stall_q, stall_d;

  logic               cand_found;
  logic [PTR_W-1:0]   cand_idx;
  logic [LEN_W-1:0]   cand_len;
  logic [N_REQ-1:0]   cand_onehot;
  logic [USEDW_W:0]   room_sum;
  logic               room_ok;

  // Candidate: lowest requester at or above the pointer, else lowest overall (wrap).
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (PTR_W'(i) >= ptr_q)) begin
        cand_found = 1'b1;
        cand_idx   = PTR_W'(i);
      end
    end
    if (!cand_found) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          cand_found = 1'b1;
          cand_idx   = PTR_W'(i);
        end
      end
    end
    cand_len    = '0;
    cand_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand_idx == PTR_W'(i)) begin
        cand_len       = req_len[i*LEN_W +: LEN_W];
        cand_onehot[i] = 1'b1;
      end
    end
    room_sum = {1'b0, fifo_usedw} + (USEDW_W+1)'(cand_len);
    room_ok  = (room_sum <= ROOM_MAX);
  end

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) fifo_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    zdone_d    = '0;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    stall_d    = stall_q;
    done       = '0;
    err        = 1'b0;
    fifo_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cand_found) begin
          if (!room_ok) begin
            if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
          end else if (!flush) begin
            ptr_d      = (cand_idx == PTR_W'(N_REQ - 1)) ? '0 : cand_idx + PTR_W'(1);
            word_idx_d = '0;
            len_d      = cand_len;
            if (cand_len == '0) begin
              // Empty message: complete without a burst, done pulses in the gap cycle.
              zdone_d = cand_onehot;
              state_d = StGap;
            end else begin
              grant_d = cand_onehot;
              state_d = StBurst;
            end
          end
        end
      end
      StBurst: begin
        fifo_wr = ~flush;
        if (flush || (word_idx_q == len_q - LEN_W'(1))) begin
          done       = grant_q;
          err        = flush;
          grant_d    = '0;
          word_idx_d = '0;
          state_d    = StGap;
        end else begin
          word_idx_d = word_idx_q + LEN_W'(1);
        end
      end
      StGap: begin
        done    = zdone_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      zdone_q    <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      ptr_q      <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      zdone_q    <= zdone_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      stall_q    <= stall_d;
    end
  end

  assign grant     = grant_q;
  assign word_idx  = word_idx_q;
  assign stall_cnt = stall_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_msg_fifo_arbiter.sv
// Bench for msg_fifo_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a timeline-based reference model.
module tb_msg_fifo_arbiter;

  logic         clk;
  logic         reset_n;
  logic [4:0]   req;
  logic [19:0]  req_len;
  logic [159:0] req_data;
  logic [4:0]   grant;
  logic [3:0]   word_idx;
  logic [4:0]   done;
  logic         err;
  logic [31:0]  fifo_data;
  logic         fifo_wr;
  logic [7:0]   fifo_usedw;
  logic         flush;
  logic         busy;
  logic [15:0]  stall_cnt;

  logic [3:0]   len_a  [5];
  logic [31:0]  base_a [5];

  int n_chk = 0;
  int n_err = 0;

  msg_fifo_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .grant      (grant),
    .word_idx   (word_idx),
    .done       (done),
    .err        (err),
    .fifo_data  (fifo_data),
    .fifo_wr    (fifo_wr),
    .fifo_usedw (fifo_usedw),
    .flush      (flush),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each producer drives base + word_idx for the word currently requested.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      req_len[i*4 +: 4]   = len_a[i];
      req_data[i*32 +: 32] = base_a[i] + {28'd0, word_idx};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    flush   = 1'b0;
    fifo_usedw = '0;
    for (int i = 0; i < 5; i++) begin
      len_a[i]  = '0;
      base_a[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reference model state (timeline form: decision cycle, end cycle, next idle cycle).
  int m_ptr, m_stall, m_owner, m_len, m_dec, m_end, m_idle_at, fill, cyc, c;
  logic [4:0]  drop, e_grant, e_done;
  logic        e_wr, e_err, e_busy;
  logic [3:0]  e_idx;
  logic [31:0] e_data;
  logic        got;
  int          o;

  initial begin
    reset_n = 1'b0;
    req = '0;
    flush = 1'b0;
    fifo_usedw = '0;
    for (int i = 0; i < 5; i++) begin
      len_a[i]  = '0;
      base_a[i] = '0;
    end
    do_reset();
    #1;
    chk("rst_grant", {27'd0, grant}, 32'd0);
    chk("rst_wr", {31'd0, fifo_wr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_done", {26'd0, err, done}, 32'd0);

    // Single request, len 3 on requester 2.
    @(negedge clk);
    reset_n = 1'b1; req = 5'b00100; len_a[2] = 4'd3; base_a[2] = 32'hA0;
    #1 chk("single_idle_wr", {31'd0, fifo_wr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("single_grant", {27'd0, grant}, 32'b00100);
      chk("single_wr", {31'd0, fifo_wr}, 32'd1);
      chk("single_data", fifo_data, 32'hA0 + k);
      chk("single_done", {27'd0, done}, (k == 2) ? 32'b00100 : 32'd0);
    end
    @(negedge clk); req = '0; #1;
    chk("single_gap_busy", {31'd0, busy}, 32'd1);
    chk("single_gap_wr", {31'd0, fifo_wr}, 32'd0);
    @(negedge clk); #1 chk("single_idle_busy", {31'd0, busy}, 32'd0);

    // Room test: usedw 253 blocks len 3 on requester 0; requester 1 must wait behind it.
    @(negedge clk);
    req = 5'b00011; len_a[0] = 4'd3; len_a[1] = 4'd1; fifo_usedw = 8'd253;
    #1 chk("room_stall0", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk); #1;
    chk("room_stall1", {16'd0, stall_cnt}, 32'd1);
    chk("room_nogrant", {27'd0, grant}, 32'd0);
    @(negedge clk); #1 chk("room_stall2", {16'd0, stall_cnt}, 32'd2);
    @(negedge clk); fifo_usedw = 8'd252; #1 chk("room_stall3", {16'd0, stall_cnt}, 32'd3);
    @(negedge clk); #1;
    chk("room_grant", {27'd0, grant}, 32'b00001);
    chk("room_wr", {31'd0, fifo_wr}, 32'd1);
    chk("room_stall_hold", {16'd0, stall_cnt}, 32'd3);

    // Synchronous reset in the middle of the burst.
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; fifo_usedw = '0; #1;
    chk("mid_rst_grant", {27'd0, grant}, 32'd0);
    chk("mid_rst_wr", {31'd0, fifo_wr}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {27'd0, done}, 32'd0);
    @(negedge clk); #1 chk("restart_grant", {27'd0, grant}, 32'b00001);

    // Flush on the second word of a len 4 burst.
    do_reset();
    reset_n = 1'b1; req = 5'b00001; len_a[0] = 4'd4;
    @(negedge clk); #1;
    chk("flush_w0_wr", {31'd0, fifo_wr}, 32'd1);
    chk("flush_w0_data", fifo_data, 32'd0);
    @(negedge clk); flush = 1'b1; #1;
    chk("flush_wr", {31'd0, fifo_wr}, 32'd0);
    chk("flush_done", {27'd0, done}, 32'b00001);
    chk("flush_err", {31'd0, err}, 32'd1);
    @(negedge clk); flush = 1'b0; req = '0; #1;
    chk("flush_gap", {30'd0, busy, fifo_wr}, 32'b10);
    chk("flush_gap_pulse", {26'd0, err, done}, 32'd0);
    @(negedge clk); #1 chk("flush_idle", {31'd0, busy}, 32'd0);

    // Zero-length message on requester 3; pointer must move to 4.
    @(negedge clk); req = 5'b01000; len_a[3] = 4'd0; #1;
    @(negedge clk); #1;
    chk("len0_done", {27'd0, done}, 32'b01000);
    chk("len0_wr", {27'd0, grant}, {31'd0, fifo_wr});
    @(negedge clk); req = '0; #1 chk("len0_idle", {31'd0, busy}, 32'd0);
    @(negedge clk); req = 5'b10001; len_a[0] = 4'd1; len_a[4] = 4'd1; #1;
    @(negedge clk); #1 chk("len0_ptr", {27'd0, grant}, 32'b10000);

    // Round-robin order with all five requesting len 2, reissued after each done.
    do_reset();
    reset_n = 1'b1; req = 5'b11111;
    for (int i = 0; i < 5; i++) len_a[i] = 4'd2;
    for (int m = 0; m < 6; m++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk); #1;
        if (done != '0) got = 1'b1;
      end
      chk("rr_done_seen", {31'd0, got}, 32'd1);
      chk("rr_order", {27'd0, done}, 32'(1 << (m % 5)));
      chk("rr_grant", {27'd0, grant}, 32'(1 << (m % 5)));
      o = m % 5;
      @(negedge clk); req[o] = 1'b0;
      @(negedge clk); req[o] = 1'b1;
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_stall = 0; m_owner = -1; m_len = 0; m_dec = 0; m_end = 0;
    m_idle_at = 0; fill = 0; cyc = 0; drop = '0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (drop[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && ($urandom_range(0, 3) == 0)) begin
          req[i]    = 1'b1;
          len_a[i]  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
          base_a[i] = $urandom;
        end
      end
      fifo_usedw = 8'(fill);
      flush = ($urandom_range(0, 799) == 0);
      #1;
      e_grant = '0; e_done = '0; e_wr = 1'b0; e_err = 1'b0; e_idx = '0; e_data = '0;
      e_busy = (cyc < m_idle_at);
      if (m_owner >= 0 && cyc > m_dec && cyc <= m_end) begin
        if (m_len == 0) begin
          e_done = 5'(1 << m_owner);
        end else begin
          e_grant = 5'(1 << m_owner);
          e_idx   = 4'(cyc - m_dec - 1);
          e_wr    = !flush;
          e_data  = base_a[m_owner] + {28'd0, e_idx};
          if (flush || cyc == m_end) begin
            e_done    = e_grant;
            e_err     = flush;
            m_end     = cyc;
            m_idle_at = cyc + 2;
          end
        end
      end
      chk("m_grant", {27'd0, grant}, {27'd0, e_grant});
      chk("m_idx", {28'd0, word_idx}, {28'd0, e_idx});
      chk("m_done", {27'd0, done}, {27'd0, e_done});
      chk("m_err", {31'd0, err}, {31'd0, e_err});
      chk("m_wr", {31'd0, fifo_wr}, {31'd0, e_wr});
      chk("m_busy", {31'd0, busy}, {31'd0, e_busy});
      chk("m_stall", {16'd0, stall_cnt}, 32'(m_stall));
      if (e_wr) chk("m_data", fifo_data, e_data);
      if (!e_busy) begin
        c = -1;
        for (int k = 0; k < 5; k++) begin
          if (c < 0 && req[(m_ptr + k) % 5]) c = (m_ptr + k) % 5;
        end
        if (c >= 0) begin
          if (fill + int'(len_a[c]) > 255) begin
            if (m_stall < 65535) m_stall++;
          end else if (!flush) begin
            m_owner   = c;
            m_len     = int'(len_a[c]);
            m_dec     = cyc;
            m_ptr     = (c + 1) % 5;
            m_end     = cyc + ((m_len == 0) ? 1 : m_len);
            m_idle_at = m_end + ((m_len == 0) ? 1 : 2);
          end
        end
      end
      drop = e_done;
      if (flush) begin
        fill = 0;
      end else begin
        fill = fill + (e_wr ? 1 : 0);
        if (fill > 0 && $urandom_range(0, 2) == 0) fill--;
      end
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
